// File: rtl/sg32_isa_pkg.sv
// SG32 instruction-set constants shared by the instruction encoder and the core's decoder.
// Type and immediate-mode codes plus the bit positions of every encoded field.
package sg32_isa_pkg;

    typedef enum logic [1:0] {
        TYPE_ALU  = 2'b00,
        TYPE_RAM  = 2'b01,
        TYPE_COND = 2'b10,
        TYPE_EXT  = 2'b11
    } instr_type_e;

    // The mode name says which register select is replaced by imm12.
    typedef enum logic [1:0] {
        IMM_NONE  = 2'b00,
        IMM_NO_RA = 2'b01,
        IMM_NO_RB = 2'b10,
        IMM_NO_RC = 2'b11
    } imm_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } enc_state_e;

    localparam int INSTR_W   = 32;
    localparam int TYPE_LSB  = 0;
    localparam int IMM_LSB   = 2;
    localparam int OP_LSB    = 4;
    localparam int F0_LSB    = 10;
    localparam int F1_LSB    = 15;
    localparam int F2_LSB    = 20;
    localparam int IMM12_LSB = 20;

endpackage

// File: rtl/instr_encoder_if.sv
// Field-tuple input stream and instruction-memory write port of the SG32 instruction encoder.
// The slave modport is the encoder; the master modport is the loader / imem side.
interface instr_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_type;
    logic [1:0]        in_imm;
    logic [5:0]        in_op;
    logic [4:0]        in_ra;
    logic [4:0]        in_rb;
    logic [4:0]        in_rc;
    logic [11:0]       in_imm12;
    logic              imem_wr_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_ready;

    modport slave (
        input  in_valid, in_type, in_imm, in_op, in_ra, in_rb, in_rc, in_imm12, imem_ready,
        output in_ready, imem_wr_en, imem_addr, imem_wdata
    );

    modport master (
        output in_valid, in_type, in_imm, in_op, in_ra, in_rb, in_rc, in_imm12, imem_ready,
        input  in_ready, imem_wr_en, imem_addr, imem_wdata
    );
endinterface

// File: rtl/enc_fifo.sv
// Synchronous FIFO holding encoded words between the accept side and the imem write side.
// Only the pointers are reset; head reads as zero while empty so outputs are clean after reset.
module enc_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // The extra pointer bit separates full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded SG32 fields into 32-bit instruction words and streams a counted burst of them
// into instruction memory at consecutive (wrapping) addresses through a small word FIFO.
module instr_encoder
    import sg32_isa_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    instr_encoder_if.slave    bus
);
    enc_state_e        state, state_nxt;
    logic [CNT_W-1:0]  target, accepted, written;
    logic [ADDR_W-1:0] wr_addr;
    logic              in_ready, push, pop;
    logic              fifo_full, fifo_empty;
    logic [31:0]       enc_word_p0, head_p1;

    function automatic logic [31:0] encode_word(
        input logic [1:0]  ty,
        input logic [1:0]  im,
        input logic [5:0]  op,
        input logic [4:0]  ra,
        input logic [4:0]  rb,
        input logic [4:0]  rc,
        input logic [11:0] imm12
    );
        logic [31:0] w;
        w = '0;
        w[TYPE_LSB +: 2] = ty;
        w[IMM_LSB  +: 2] = im;
        w[OP_LSB   +: 6] = op;
        if (ty == TYPE_EXT) begin
            w[F0_LSB +: 5]     = ra;
            w[F1_LSB +: 5]     = rb;
            w[IMM12_LSB +: 12] = imm12;
        end else begin
            case (im)
                IMM_NONE: begin
                    w[F0_LSB +: 5] = ra;
                    w[F1_LSB +: 5] = rb;
                    w[F2_LSB +: 5] = rc;
                end
                IMM_NO_RA: begin
                    w[F0_LSB +: 5]     = rb;
                    w[F1_LSB +: 5]     = rc;
                    w[IMM12_LSB +: 12] = imm12;
                end
                IMM_NO_RB: begin
                    w[F0_LSB +: 5]     = ra;
                    w[F1_LSB +: 5]     = rc;
                    w[IMM12_LSB +: 12] = imm12;
                end
                default: begin
                    w[F0_LSB +: 5]     = ra;
                    w[F1_LSB +: 5]     = rb;
                    w[IMM12_LSB +: 12] = imm12;
                end
            endcase
        end
        return w;
    endfunction

    // Stage p0: combinational encode of the tuple being accepted this cycle.
    assign enc_word_p0 = encode_word(bus.in_type, bus.in_imm, bus.in_op,
                                     bus.in_ra, bus.in_rb, bus.in_rc, bus.in_imm12);
    assign push = bus.in_valid && in_ready;
    assign pop  = !fifo_empty && bus.imem_ready;

    // Stage p1: FIFO head drives the imem write port.
    enc_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (enc_word_p0),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head_p1)
    );

    assign bus.in_ready   = in_ready;
    assign bus.imem_wr_en = !fifo_empty;
    assign bus.imem_addr  = wr_addr;
    assign bus.imem_wdata = head_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = (count != '0) ? ST_RUN : ST_DONE;
            end
            ST_RUN: begin
                busy     = 1'b1;
                in_ready = !fifo_full && (accepted < target);
                if (pop && (written + CNT_W'(1) == target)) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr  <= '0;
            target   <= '0;
            accepted <= '0;
            written  <= '0;
        end else if (state == ST_IDLE) begin
            if (start && count != '0) begin
                wr_addr  <= base_addr;
                target   <= count;
                accepted <= '0;
                written  <= '0;
            end
        end else if (state == ST_RUN) begin
            if (push) accepted <= accepted + CNT_W'(1);
            if (pop) begin
                wr_addr <= wr_addr + ADDR_W'(1);
                written <= written + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-computed SG32 words, back-pressure, wrap, zero-count,
// ignored start and asynchronous mid-burst reset.
module tb_instr_encoder;

    typedef struct {
        logic [1:0]  ty;
        logic [1:0]  im;
        logic [5:0]  op;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rc;
        logic [11:0] i12;
    } tup_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] count;
    logic        busy, done;

    instr_encoder_if #(.ADDR_W(10)) bus ();

    instr_encoder #(
        .ADDR_W     (10),
        .FIFO_DEPTH (4),
        .CNT_W      (11)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int         n_vec  = 0;
    int         n_miss = 0;
    int         done_cnt = 0;
    int         idx = 0;
    tup_t       tab[$];
    logic [9:0] wa_q[$];
    logic [31:0] wd_q[$];

    // Capture every completed imem write; handshake is stable around the falling edge.
    always @(negedge clk) begin
        if (rst_n && bus.imem_wr_en && bus.imem_ready) begin
            wa_q.push_back(bus.imem_addr);
            wd_q.push_back(bus.imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic tup_t mk(input logic [1:0] ty, input logic [1:0] im, input logic [5:0] op,
                                input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rc,
                                input logic [11:0] i12);
        tup_t t;
        t.ty = ty; t.im = im; t.op = op; t.ra = ra; t.rb = rb; t.rc = rc; t.i12 = i12;
        return t;
    endfunction

    // One clock: offer the next table tuple, sample at the falling edge, advance after the rise.
    task automatic step();
        logic acc;
        if (idx < tab.size()) begin
            bus.in_valid = 1'b1;
            bus.in_type  = tab[idx].ty;
            bus.in_imm   = tab[idx].im;
            bus.in_op    = tab[idx].op;
            bus.in_ra    = tab[idx].ra;
            bus.in_rb    = tab[idx].rb;
            bus.in_rc    = tab[idx].rc;
            bus.in_imm12 = tab[idx].i12;
        end else begin
            bus.in_valid = 1'b0;
        end
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        if (done) done_cnt++;
        @(posedge clk);
        #1;
        if (acc) idx++;
    endtask

    task automatic pulse_start(input logic [9:0] b, input logic [10:0] c);
        base_addr = b;
        count     = c;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic run_until_done(input string tag, input int max);
        int n;
        n = 0;
        while (done_cnt == 0 && n < max) begin
            step();
            n++;
        end
        chk(tag, 32'(done_cnt != 0), 32'd1);
    endtask

    task automatic new_burst_setup();
        tab.delete();
        wa_q.delete();
        wd_q.delete();
        idx      = 0;
        done_cnt = 0;
    endtask

    task automatic chk_writes(input string tag, input logic [9:0] a[], input logic [31:0] d[]);
        chk({tag, "_nwr"}, 32'(wa_q.size()), 32'(a.size()));
        for (int i = 0; i < a.size() && i < wa_q.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 32'(wa_q[i]), 32'(a[i]));
            chk($sformatf("%s_data%0d", tag, i), wd_q[i], d[i]);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0;
        bus.in_valid = 1'b0; bus.in_type = '0; bus.in_imm = '0; bus.in_op = '0;
        bus.in_ra = '0; bus.in_rb = '0; bus.in_rc = '0; bus.in_imm12 = '0;
        bus.imem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_inrdy", 32'(bus.in_ready), 32'd0);
        chk("rst_wren",  32'(bus.imem_wr_en), 32'd0);
        chk("rst_addr",  32'(bus.imem_addr), 32'd0);
        chk("rst_wdata", bus.imem_wdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single ALU register-form word.
        new_burst_setup();
        tab.push_back(mk(2'b00, 2'b00, 6'h05, 5'd1, 5'd2, 5'd3, 12'h000));
        pulse_start(10'h010, 11'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        step();
        chk("t1_lat_wren", 32'(bus.imem_wr_en), 32'd1);
        chk("t1_lat_addr", 32'(bus.imem_addr), 32'h010);
        chk("t1_lat_wdata", bus.imem_wdata, 32'h00310450);
        run_until_done("t1_done", 20);
        step();
        chk("t1_done_once", 32'(done_cnt), 32'd1);
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk_writes("t1", '{10'h010}, '{32'h00310450});

        // Immediate modes and ext type.
        new_burst_setup();
        tab.push_back(mk(2'b00, 2'b11, 6'h05, 5'd1, 5'd2, 5'd0, 12'hABC));
        tab.push_back(mk(2'b01, 2'b01, 6'h00, 5'd9, 5'd4, 5'd7, 12'h123));
        tab.push_back(mk(2'b11, 2'b01, 6'h3F, 5'd31, 5'd0, 5'd5, 12'hFFF));
        tab.push_back(mk(2'b10, 2'b10, 6'h2A, 5'd3, 5'd9, 5'h11, 12'h5A5));
        pulse_start(10'h100, 11'd4);
        run_until_done("t2_done", 40);
        chk_writes("t2", '{10'h100, 10'h101, 10'h102, 10'h103},
                   '{32'hABC1045C, 32'h12339005, 32'hFFF07FF7, 32'h5A588EAA});

        // Back-pressure: FIFO fills, outputs hold, then drains in order.
        new_burst_setup();
        for (int k = 1; k <= 6; k++)
            tab.push_back(mk(2'b00, 2'b00, 6'(k), 5'(k), 5'd0, 5'd0, 12'h000));
        bus.imem_ready = 1'b0;
        pulse_start(10'h020, 11'd6);
        chk("t3_wdata_first", bus.imem_wdata, 32'h00000000);
        for (int c = 0; c < 10; c++) step();
        chk("t3_accepts", 32'(idx), 32'd4);
        chk("t3_inrdy", 32'(bus.in_ready), 32'd0);
        chk("t3_wren", 32'(bus.imem_wr_en), 32'd1);
        chk("t3_addr_hold", 32'(bus.imem_addr), 32'h020);
        chk("t3_wdata_hold", bus.imem_wdata, 32'h00000410);
        chk("t3_nowrite", 32'(wa_q.size()), 32'd0);
        bus.imem_ready = 1'b1;
        run_until_done("t3_done", 60);
        chk_writes("t3", '{10'h020, 10'h021, 10'h022, 10'h023, 10'h024, 10'h025},
                   '{32'h00000410, 32'h00000820, 32'h00000C30,
                     32'h00001040, 32'h00001450, 32'h00001860});

        // Address wrap at the top of imem.
        new_burst_setup();
        for (int k = 1; k <= 3; k++)
            tab.push_back(mk(2'b00, 2'b00, 6'(k), 5'(k), 5'd0, 5'd0, 12'h000));
        pulse_start(10'h3FE, 11'd3);
        run_until_done("t4_done", 40);
        chk_writes("t4", '{10'h3FE, 10'h3FF, 10'h000},
                   '{32'h00000410, 32'h00000820, 32'h00000C30});

        // Zero-length burst.
        new_burst_setup();
        pulse_start(10'h155, 11'd0);
        chk("t5_zc_done", 32'(done), 32'd1);
        chk("t5_zc_busy", 32'(busy), 32'd1);
        step();
        chk("t5_zc_done_off", 32'(done), 32'd0);
        chk("t5_zc_idle", 32'(busy), 32'd0);
        chk("t5_zc_nowrite", 32'(wa_q.size()), 32'd0);

        // start during RUN is ignored.
        new_burst_setup();
        tab.push_back(mk(2'b00, 2'b00, 6'h05, 5'd1, 5'd2, 5'd3, 12'h000));
        tab.push_back(mk(2'b00, 2'b11, 6'h05, 5'd1, 5'd2, 5'd0, 12'hABC));
        pulse_start(10'h050, 11'd2);
        pulse_start(10'h200, 11'd5);
        run_until_done("t5_run_done", 40);
        repeat (3) step();
        chk("t5_run_idle", 32'(busy), 32'd0);
        chk_writes("t5", '{10'h050, 10'h051}, '{32'h00310450, 32'hABC1045C});

        // Asynchronous reset mid-burst, then a clean burst.
        new_burst_setup();
        for (int k = 1; k <= 5; k++)
            tab.push_back(mk(2'b00, 2'b00, 6'(k), 5'(k), 5'd0, 5'd0, 12'h000));
        pulse_start(10'h060, 11'd5);
        for (int c = 0; c < 30 && wa_q.size() < 2; c++) step();
        chk("t6_pre_wren", 32'(bus.imem_wr_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_wren",  32'(bus.imem_wr_en), 32'd0);
        chk("t6_rst_addr",  32'(bus.imem_addr), 32'd0);
        chk("t6_rst_wdata", bus.imem_wdata, 32'd0);
        chk("t6_rst_busy",  32'(busy), 32'd0);
        chk("t6_rst_inrdy", 32'(bus.in_ready), 32'd0);
        chk_writes("t6a", '{10'h060, 10'h061}, '{32'h00000410, 32'h00000820});
        @(posedge clk); #1;
        rst_n = 1'b1;
        new_burst_setup();
        tab.push_back(mk(2'b00, 2'b11, 6'h05, 5'd1, 5'd2, 5'd0, 12'hABC));
        tab.push_back(mk(2'b01, 2'b01, 6'h00, 5'd9, 5'd4, 5'd7, 12'h123));
        chk("t6_post_empty", 32'(bus.imem_wr_en), 32'd0);
        pulse_start(10'h070, 11'd2);
        run_until_done("t6_done", 40);
        chk_writes("t6b", '{10'h070, 10'h071}, '{32'hABC1045C, 32'h12339005});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
